// File: rtl/lane_writeback_queue.sv
// Lane writeback queue: FIFO between the lane ALU and the VRF write port,
// packing mask-result beats into full mask words. Optional LANE_WB_BYPASS_EN.
module lane_writeback_queue #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int REG_BITS   = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  input  logic                    in_mask_wb,
  input  logic [2:0]              in_sew,
  input  logic [REG_BITS-1:0]     in_dst,
  input  logic                    in_last,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic [REG_BITS-1:0]     wr_addr,
  output logic [DATA_WIDTH/8-1:0] wr_be,
  output logic                    done
);

  localparam int BE_W = DATA_WIDTH / 8;
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;
  localparam int BW   = $clog2(DATA_WIDTH) + 1;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [REG_BITS-1:0]   addr;
    logic [BE_W-1:0]       be;
    logic                  last;
  } entry_t;

  typedef enum logic {EMPTY, ACCUM} state_t;

  function automatic logic [BE_W-1:0] bytes_written(input logic [BW-1:0] bits);
    logic [BE_W-1:0] be;
    be = '0;
    for (int k = 0; k < BE_W; k++) be[k] = (BW'(8 * k) < bits);
    return be;
  endfunction

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] acc_data;
  logic [BW-1:0]         acc_bits;
  logic [REG_BITS-1:0]   acc_dst;

  entry_t [DEPTH-1:0]    mem;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;

  logic [1:0]            sew_eff;
  logic [BW-1:0]         n_elem, sum;
  logic [DATA_WIDTH-1:0] elem_mask, merged;
  logic                  full_word, not_full, conflict, accept;
  logic                  push, acc_load, acc_clear;
  entry_t                push_e, head, out_e;
  logic                  bypass, fifo_push, fifo_pop;

  // Element count per beat; codes above 3 behave as 64-bit elements.
  assign sew_eff   = in_sew[2] ? 2'd3 : in_sew[1:0];
  assign n_elem    = BW'(DATA_WIDTH >> (3 + int'(sew_eff)));
  assign elem_mask = (DATA_WIDTH'(1) << n_elem) - DATA_WIDTH'(1);
  // The accumulator is kept zeroed while EMPTY, so one merge path serves both states.
  assign merged    = acc_data | ((in_data & elem_mask) << acc_bits);
  assign sum       = acc_bits + n_elem;
  assign full_word = (sum >= BW'(DATA_WIDTH));

  assign not_full = (count < CW'(DEPTH));
  assign conflict = (state == ACCUM) && in_valid && (!in_mask_wb || (in_dst != acc_dst));
  assign in_ready = not_full && !conflict;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= EMPTY;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: if (accept && in_mask_wb && !(full_word || in_last)) state_nxt = ACCUM;
      ACCUM: begin
        if (conflict && not_full)                    state_nxt = EMPTY;
        else if (accept && (full_word || in_last))   state_nxt = EMPTY;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_comb begin
    push      = 1'b0;
    push_e    = '0;
    acc_load  = 1'b0;
    acc_clear = 1'b0;
    if (conflict) begin
      // Forced flush: the held beat is not consumed, so last is never set here.
      if (not_full) begin
        push      = 1'b1;
        push_e    = {acc_data, acc_dst, bytes_written(acc_bits), 1'b0};
        acc_clear = 1'b1;
      end
    end else if (accept) begin
      if (!in_mask_wb) begin
        push   = 1'b1;
        push_e = {in_data, in_dst, {BE_W{1'b1}}, in_last};
      end else if (full_word || in_last) begin
        push      = 1'b1;
        push_e    = {merged, in_dst, bytes_written(sum), in_last};
        acc_clear = 1'b1;
      end else begin
        acc_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_data <= '0;
      acc_bits <= '0;
      acc_dst  <= '0;
    end else if (acc_clear) begin
      acc_data <= '0;
      acc_bits <= '0;
    end else if (acc_load) begin
      acc_data <= merged;
      acc_bits <= sum;
      acc_dst  <= in_dst;
    end
  end

`ifdef LANE_WB_BYPASS_EN
  assign bypass = push && (count == '0) && wr_ready;
`else
  assign bypass = 1'b0;
`endif

  assign head      = mem[rd_ptr];
  assign fifo_pop  = (count != '0) && wr_ready;
  assign fifo_push = push && !bypass;

  // Outputs are zero whenever nothing is presented.
  assign out_e    = bypass ? push_e : ((count != '0) ? head : '0);
  assign wr_valid = (count != '0) || bypass;
  assign wr_data  = out_e.data;
  assign wr_addr  = out_e.addr;
  assign wr_be    = out_e.be;

  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr] <= push_e;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      done   <= 1'b0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + PW'(1);
      if (fifo_pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(fifo_push) - CW'(fifo_pop);
      done  <= (fifo_pop && head.last) || (bypass && push_e.last);
    end
  end

endmodule

// File: tb/tb_lane_writeback_queue.sv
// Bench for lane_writeback_queue: directed scenarios followed by a randomized
// stream checked against a transaction-level packing model.
module tb_lane_writeback_queue;
  localparam int DW = 64;
  localparam int DEPTH = 4;
  localparam int RB = 5;

  logic          clk = 1'b0, rst = 1'b1;
  logic          in_valid = 1'b0, in_ready, in_mask_wb = 1'b0, in_last = 1'b0;
  logic [DW-1:0] in_data = '0, wr_data;
  logic [2:0]    in_sew = '0;
  logic [RB-1:0] in_dst = '0, wr_addr;
  logic          wr_valid, wr_ready = 1'b0, done;
  logic [7:0]    wr_be;

  lane_writeback_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .REG_BITS(RB)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_mask_wb(in_mask_wb), .in_sew(in_sew), .in_dst(in_dst), .in_last(in_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_addr(wr_addr),
    .wr_be(wr_be), .done(done));

  always #5 clk = ~clk;

  typedef struct {logic [63:0] d; logic [4:0] a; logic [7:0] be; int c;} wr_t;
  typedef struct {logic [63:0] d; logic [4:0] a; logic [7:0] be; bit last;} exp_t;

  int   checks = 0, errors = 0, cyc = 0;
  bit   mon_en = 1'b0;
  wr_t  wq[$];
  int   dq[$];
  exp_t eq[$];
  bit          grp_open = 1'b0;
  logic [4:0]  grp_dst;
  logic [63:0] grp_data;
  int          grp_bits, mn;
  wr_t         wt;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] be_of(int bits);
    logic [7:0] b;
    for (int k = 0; k < 8; k++) b[k] = (8 * k < bits);
    return b;
  endfunction

  task automatic emit(logic [63:0] d, logic [4:0] a, int bits, bit last);
    exp_t e;
    e.d = d; e.a = a; e.be = be_of(bits); e.last = last;
    eq.push_back(e);
  endtask

  // Write/done capture plus the reference model: mask beats to one register
  // are concatenated bitwise until a full word, last, or an interrupting beat.
  always @(negedge clk) begin
    if (rst && wr_valid && wr_ready) begin
      wt.d = wr_data; wt.a = wr_addr; wt.be = wr_be; wt.c = cyc;
      wq.push_back(wt);
    end
    if (rst && done) dq.push_back(cyc);
    if (!rst) begin
      grp_open = 1'b0;
    end else if (mon_en && in_valid) begin
      if (grp_open && (!in_mask_wb || in_dst != grp_dst)) begin
        emit(grp_data, grp_dst, grp_bits, 1'b0);
        grp_open = 1'b0;
      end
      if (in_ready) begin
        if (!in_mask_wb) emit(in_data, in_dst, 64, in_last);
        else begin
          if (!grp_open) begin
            grp_open = 1'b1; grp_dst = in_dst; grp_data = '0; grp_bits = 0;
          end
          mn = DW >> (3 + ((in_sew > 3) ? 3 : int'(in_sew)));
          for (int i = 0; i < mn; i++)
            if (grp_bits + i < 64) grp_data[grp_bits + i] = in_data[i];
          grp_bits += mn;
          if (grp_bits >= 64 || in_last) begin
            emit(grp_data, grp_dst, grp_bits, in_last);
            grp_open = 1'b0;
          end
        end
      end
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive(logic [63:0] d, bit m, logic [2:0] s, logic [4:0] dst, bit l);
    in_valid = 1'b1; in_data = d; in_mask_wb = m; in_sew = s; in_dst = dst; in_last = l;
  endtask

  task automatic send(logic [63:0] d, bit m, logic [2:0] s, logic [4:0] dst, bit l, bit rnd);
    bit ok = 1'b0;
    drive(d, m, s, dst, l);
    for (int i = 0; i < 64 && !ok; i++) begin
      if (rnd) wr_ready = 1'($urandom_range(0, 1));
      @(negedge clk); ok = in_ready;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
    repeat (2) tick();
    wq.delete(); dq.delete(); eq.delete();
    rst = 1'b1;
    tick();
  endtask

  initial begin
    logic [63:0] d;
    logic [4:0]  cur, dst;
    int edl[$];
    int nmin;

    // Reset values
    #2 rst = 1'b0;
    #1;
    chk("rst_wr_valid", 64'(wr_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_wr_addr", 64'(wr_addr), 64'd0);
    chk("rst_wr_be", 64'(wr_be), 64'd0);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // Reset mid-fill drops queued beats, including one marked last
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(64'(i + 1), 1'b0, 3'd0, 5'd7, i == 2, 1'b0);
    chk("fill_wr_valid", 64'(wr_valid), 64'd1);
    rst = 1'b0;
    #1;
    chk("midrst_wr_valid", 64'(wr_valid), 64'd0);
    chk("midrst_wr_data", wr_data, 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    wr_ready = 1'b1;
    repeat (6) tick();
    chk("midrst_writes", 64'(wq.size()), 64'd0);
    chk("midrst_done", 64'(dq.size()), 64'd0);

    // Normal stream
    do_reset();
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send(64'h11 * 64'(i + 1), 1'b0, 3'd0, 5'd3, i == 7, 1'b0);
      if (i == 0) chk("latency_1", 64'(wr_valid), 64'd1);
    end
    repeat (4) tick();
    chk("norm_count", 64'(wq.size()), 64'd8);
    for (int i = 0; i < wq.size(); i++) begin
      chk("norm_data", wq[i].d, 64'h11 * 64'(i + 1));
      chk("norm_addr", 64'(wq[i].a), 64'd3);
      chk("norm_be", 64'(wq[i].be), 64'hFF);
    end
    chk("norm_done_cnt", 64'(dq.size()), 64'd1);
    if (dq.size() > 0 && wq.size() >= 8) chk("norm_done_cyc", 64'(dq[0]), 64'(wq[7].c + 1));

    // Mask packing, one bit per beat, upper data bits are noise
    do_reset();
    wr_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      d = {$urandom(), $urandom()};
      d[0] = (i % 2 == 0);
      send(d, 1'b1, 3'd3, 5'd5, 1'b0, 1'b0);
    end
    repeat (3) tick();
    chk("pack64_count", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      chk("pack64_data", wq[0].d, 64'h5555_5555_5555_5555);
      chk("pack64_be", 64'(wq[0].be), 64'hFF);
      chk("pack64_addr", 64'(wq[0].a), 64'd5);
    end
    chk("pack64_done", 64'(dq.size()), 64'd0);

    // Partial mask word closed by last
    do_reset();
    wr_ready = 1'b1;
    d = {$urandom(), $urandom()}; d[1:0] = 2'b11; send(d, 1'b1, 3'd2, 5'd4, 1'b0, 1'b0);
    d = {$urandom(), $urandom()}; d[1:0] = 2'b01; send(d, 1'b1, 3'd2, 5'd4, 1'b0, 1'b0);
    d = {$urandom(), $urandom()}; d[1:0] = 2'b10; send(d, 1'b1, 3'd2, 5'd4, 1'b1, 1'b0);
    repeat (3) tick();
    chk("partial_count", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      chk("partial_data", wq[0].d, 64'h27);
      chk("partial_be", 64'(wq[0].be), 64'h01);
    end
    chk("partial_done", 64'(dq.size()), 64'd1);

    // Destination change forces a flush and a one-cycle stall
    do_reset();
    wr_ready = 1'b1;
    d = {$urandom(), $urandom()}; d[7:0] = 8'hA5;
    send(d, 1'b1, 3'd0, 5'd1, 1'b0, 1'b0);
    drive(64'h3C, 1'b1, 3'd0, 5'd2, 1'b0);
    #1;
    chk("dst_stall", 64'(in_ready), 64'd0);
    tick();
    chk("dst_resume", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    chk("dst_count", 64'(wq.size()), 64'd1);
    if (wq.size() > 0) begin
      chk("dst_data", wq[0].d, 64'hA5);
      chk("dst_be", 64'(wq[0].be), 64'h01);
      chk("dst_addr", 64'(wq[0].a), 64'd1);
    end
    chk("dst_no_done", 64'(dq.size()), 64'd0);
    send(64'h01, 1'b1, 3'd0, 5'd2, 1'b1, 1'b0);
    repeat (3) tick();
    chk("dst_v2_count", 64'(wq.size()), 64'd2);
    if (wq.size() > 1) begin
      chk("dst_v2_data", wq[1].d, 64'h013C);
      chk("dst_v2_be", 64'(wq[1].be), 64'h03);
    end
    chk("dst_v2_done", 64'(dq.size()), 64'd1);

    // Backpressure at full queue
    do_reset();
    wr_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(64'hB0 + 64'(i), 1'b0, 3'd0, 5'd6, 1'b0, 1'b0);
    drive(64'hB0 + 64'(DEPTH), 1'b0, 3'd0, 5'd6, 1'b1);
    #1;
    chk("full_stall", 64'(in_ready), 64'd0);
    chk("full_wr_valid", 64'(wr_valid), 64'd1);
    tick();
    wr_ready = 1'b1;
    #1;
    chk("full_stall_wr_ready", 64'(in_ready), 64'd0);
    tick();
    wr_ready = 1'b0;
    chk("after_pop_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("bp_one_pop", 64'(wq.size()), 64'd1);
    wr_ready = 1'b1;
    repeat (8) tick();
    chk("bp_count", 64'(wq.size()), 64'(DEPTH + 1));
    for (int i = 0; i < wq.size(); i++) chk("bp_data", wq[i].d, 64'hB0 + 64'(i));
    chk("bp_done", 64'(dq.size()), 64'd1);

    // Randomized stream against the packing model
    do_reset();
    mon_en = 1'b1;
    cur = 5'd1;
    for (int b = 0; b < 200; b++) begin
      if ($urandom_range(0, 4) == 0) begin
        wr_ready = 1'($urandom_range(0, 1));
        tick();
      end
      dst = ($urandom_range(0, 4) == 0) ? (cur ^ 5'd3) : cur;
      cur = dst;
      send({$urandom(), $urandom()}, $urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
           dst, $urandom_range(0, 9) == 0, 1'b1);
    end
    send({$urandom(), $urandom()}, 1'b0, 3'd0, cur, 1'b1, 1'b1);
    wr_ready = 1'b1;
    for (int i = 0; i < 100 && wq.size() < eq.size(); i++) tick();
    repeat (3) tick();
    mon_en = 1'b0;
    chk("rand_count", 64'(wq.size()), 64'(eq.size()));
    nmin = (wq.size() < eq.size()) ? wq.size() : eq.size();
    for (int i = 0; i < nmin; i++) begin
      chk("rand_data", wq[i].d, eq[i].d);
      chk("rand_addr", 64'(wq[i].a), 64'(eq[i].a));
      chk("rand_be", 64'(wq[i].be), 64'(eq[i].be));
      if (eq[i].last) edl.push_back(wq[i].c + 1);
    end
    chk("rand_done_cnt", 64'(dq.size()), 64'(edl.size()));
    for (int i = 0; i < dq.size() && i < edl.size(); i++)
      chk("rand_done_cyc", 64'(dq[i]), 64'(edl[i]));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/lane_writeback_queue.md
# lane_writeback_queue

Per-lane writeback stage directly downstream of the lane ALU. It accepts one ALU result per beat under a valid/ready handshake and queues it for the vector register file write port. Mask-producing results (compare ops, flagged by the ALU's masked-write-back signal) carry one bit per element in their low bits. For those beats the block packs the bits from consecutive beats into a single mask word before writing. It also raises a completion pulse when the last write of an instruction leaves the queue.

## Interface
- DATA_WIDTH, 64, lane datapath width in bits (multiple of 64)
- DEPTH, 4, queue entries (power of two, ≥2)
- REG_BITS, 5, vector register index width

- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  ALU beat valid
- in_ready  output  1  beat accepted when in_valid && in_ready
- in_data  input  DATA_WIDTH  ALU result
- in_mask_wb  input  1  beat is a mask result (element bits in low bits)
- in_sew  input  3  element width code, 0..3 = 8/16/32/64 bits
- in_dst  input  REG_BITS  destination register
- in_last  input  1  final beat of the instruction in this lane
- wr_valid  output  1  write request to register file
- wr_ready  input  1  register file accepts write
- wr_data  output  DATA_WIDTH  write data
- wr_addr  output  REG_BITS  write register
- wr_be  output  DATA_WIDTH/8  byte enables
- done  output  1  one-cycle pulse: popped entry had last=1

## Operation
- Queue: circular FIFO with DEPTH entries of {data, addr, be, last}. It uses a registered occupancy count and read/write pointers that wrap modulo DEPTH.
- wr_valid = count≠0. An entry pops on wr_valid && wr_ready.
- Normal beat (in_mask_wb=0): push {in_data, in_dst, all-ones be, in_last}.
- Mask beat: element count n = DATA_WIDTH >> (3+in_sew). in_sew values 4..7 are treated as 3.
  - in_data[n-1:0] is written into the accumulator at bit offset acc_bits.
  - acc_bits is then increased by n.
- Accumulator FSM: two states, EMPTY and ACCUM.
  - EMPTY + mask beat: load acc_dst=in_dst and acc_bits=n.
    - If n==DATA_WIDTH or in_last, push immediately and stay in EMPTY.
    - Otherwise go to ACCUM.
  - ACCUM + mask beat, same dst: merge the bits.
    - If acc_bits+n==DATA_WIDTH or in_last, push and go to EMPTY.
  - ACCUM + beat that is non-mask or has a different dst: flush the accumulator this cycle and hold in_ready low, so the beat is not accepted. Go to EMPTY. The beat is taken on a later cycle.
- Pushed mask entry contents:
  - Unwritten accumulator bits are 0.
  - wr_be[k]=1 iff any bit of byte k was written.
  - last is in_last for a flush caused by in_last. It is 0 for a flush forced by a dst change or a non-mask beat.
- in_ready = (count<DEPTH) && !(ACCUM && in_valid && (!in_mask_wb || in_dst≠acc_dst)).
  - A beat that only accumulates (no push) also requires count<DEPTH.
- A flush push needs a free slot. If count==DEPTH, the flush waits, the state stays ACCUM, and in_ready stays low.
- done asserts for the cycle after a pop whose entry has last=1.

## Timing
- Reset (rst=0, asynchronous) clears:
  - count and pointers to 0, FSM to EMPTY, acc_bits to 0
  - wr_valid=0, done=0, wr_data/wr_addr/wr_be=0
  - in_ready=1 after reset release
- Latency: accepted beat that pushes → wr_valid on the next cycle.
- Full queue: a pop and a push may occur in the same cycle only when count<DEPTH. At count==DEPTH, in_ready=0 even if wr_ready=1.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- wr_data/wr_addr/wr_be are stable while wr_valid && !wr_ready.
- Reset mid-burst: all queued entries and any partial accumulator are discarded, and no done pulse is generated.

## Configuration
- LANE_WB_BYPASS_EN
  - Defined: when count==0, a push is produced, and wr_ready=1, the entry drives wr_* combinationally that cycle and is not stored. Latency is 0, and done pulses the next cycle if last=1.
  - Undefined: every entry passes through the FIFO, latency 1.

## Test plan
- Reset mid-fill: push 3 normal beats with wr_ready=0, then assert rst=0 → count=0 and wr_valid=0. After release in_ready=1, and no done pulse ever appears for the dropped beats.
- Normal stream: wr_ready=1, 8 beats with data 0x11..0x88, dst=3, last on the 8th → 8 writes in order, wr_be=0xFF, done pulses once, one cycle after the 8th write.
- Mask packing, DATA_WIDTH=64, sew=3: 64 beats each with bit0 alternating 1,0 → exactly one write, data 0x5555_5555_5555_5555, wr_be=0xFF.
- Partial mask, sew=2: 3 beats with low bits 2'b11, 2'b01, 2'b10, last on the 3rd → one write with data 0x27, wr_be=0x01, done pulses.
- dst change: sew=0 mask beat to v1 (low byte 0xA5), then a mask beat to v2 → the v2 beat stalls one cycle (in_ready=0) and v1 is written with data 0xA5, wr_be=0x01, no done pulse. The v2 beat is accepted the next cycle.
- Backpressure: wr_ready=0, push DEPTH normal beats → in_ready=0 at count==DEPTH. Raise wr_ready for 1 cycle → one pop and count=DEPTH-1, then the next beat is accepted in the following cycle.
